// File: rtl/pm64_issue_ctrl.sv
// pm64_issue_ctrl: issues buffered 64-bit operands to a pipelined operator and collects
// in-order results. Define PM64_TIMEOUT_EN to enable the DRAIN watchdog (LAT_MAX idle cycles).
module pm64_issue_ctrl #(
  parameter int DEPTH   = 8,
  parameter int LAT_MAX = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rst_user,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [63:0]              wr_data,
  input  logic                     start,
  input  logic [4:0]               n_ops,
  output logic                     op_sta,
  output logic [63:0]              op_x,
  input  logic                     op_done,
  input  logic [63:0]              op_y,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [63:0]              rd_data,
  output logic                     busy,
  output logic                     done_sig,
  output logic                     timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d, cnt_sat;
  logic [IW-1:0] iss_idx_q, iss_idx_d;
  logic [IW-1:0] ret_idx_q, ret_idx_d;
  logic [63:0]   rd_data_q, rd_data_d;
  logic [63:0]   opnd_mem [DEPTH];
  logic [63:0]   res_mem  [DEPTH];
  logic          accept, opnd_we, res_we, tmo_fire;

  // Results are accepted only while a batch is live and not all of them are back.
  assign accept  = op_done && ((state_q == ISSUE) || (state_q == DRAIN)) && (ret_idx_q < cnt_q);
  assign res_we  = accept && !rst_user;
  assign opnd_we = wr_en && !busy && !rst_user;
  assign cnt_sat = ({1'b0, n_ops} > 6'(DEPTH)) ? IW'(DEPTH) : IW'(n_ops);

`ifdef PM64_TIMEOUT_EN
  localparam int TW = $clog2(LAT_MAX + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_err_q, tmo_err_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_err_d = tmo_err_q;
    tmo_fire  = 1'b0;
    if (rst_user || (state_q == IDLE && start)) begin
      tmo_cnt_d = '0;
      tmo_err_d = 1'b0;
    end else if (op_sta || accept) begin
      tmo_cnt_d = '0;
    end else if (state_q == DRAIN && ret_idx_q < cnt_q) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
      if (tmo_cnt_d == TW'(LAT_MAX)) begin
        tmo_fire  = 1'b1;
        tmo_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      iss_idx_q <= '0;
      ret_idx_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      iss_idx_q <= iss_idx_d;
      ret_idx_q <= ret_idx_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    iss_idx_d = iss_idx_q;
    ret_idx_d = accept ? ret_idx_q + IW'(1) : ret_idx_q;
    rd_data_d = rst_user ? '0 : res_mem[rd_addr];
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d     = cnt_sat;
          iss_idx_d = '0;
          ret_idx_d = '0;
          state_d   = (cnt_sat == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        iss_idx_d = iss_idx_q + IW'(1);
        if (iss_idx_d == cnt_q) state_d = (ret_idx_d == cnt_q) ? FINISH : DRAIN;
      end
      DRAIN:   if (ret_idx_d == cnt_q) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo_fire) state_d = IDLE;
    if (rst_user) begin
      state_d   = IDLE;
      cnt_d     = '0;
      iss_idx_d = '0;
      ret_idx_d = '0;
    end
  end

  always_comb begin
    op_sta   = (state_q == ISSUE);
    op_x     = op_sta ? opnd_mem[iss_idx_q[AW-1:0]] : '0;
    busy     = (state_q == ISSUE) || (state_q == DRAIN);
    done_sig = (state_q == FINISH);
  end

  // Buffers carry no reset so their contents survive rst_user.
  always_ff @(posedge clk) begin
    if (opnd_we) opnd_mem[wr_addr] <= wr_data;
    if (res_we)  res_mem[ret_idx_q[AW-1:0]] <= op_y;
  end

  assign rd_data = rd_data_q;
endmodule

// File: tb/tb_pm64_issue_ctrl.sv
// Self-checking bench for pm64_issue_ctrl: directed and randomized batches against a cycle-level
// expectation model (issue window, busy window, done cycle) and a result-buffer scoreboard.
module tb_pm64_issue_ctrl;
  localparam int DEPTH   = 8;
  localparam int LAT_MAX = 15;
  localparam int AW      = $clog2(DEPTH);

  logic          clk = 1'b0, rst = 1'b1, rst_user = 1'b0, wr_en = 1'b0, start = 1'b0, op_done = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [63:0]   wr_data = '0, op_y = '0;
  logic [4:0]    n_ops = '0;
  logic          op_sta, busy, done_sig, timeout_err;
  logic [63:0]   op_x, rd_data;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] ops    [DEPTH];
  logic        resp_v [64];
  logic [63:0] resp_y [64];

  always #5 clk = ~clk;

  pm64_issue_ctrl #(.DEPTH(DEPTH), .LAT_MAX(LAT_MAX)) dut (
    .clk(clk), .rst(rst), .rst_user(rst_user),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .n_ops(n_ops),
    .op_sta(op_sta), .op_x(op_x), .op_done(op_done), .op_y(op_y),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done_sig(done_sig), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bench operator function: mode 0 is max(x, 0.0) on doubles, mode 1 is integer 3x+1.
  function automatic logic [63:0] f(input int mode, input logic [63:0] x);
    if (mode == 0) return ($bitstoreal(x) > 0.0) ? x : 64'h0;
    return x * 64'd3 + 64'd1;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < DEPTH; i++) ops[i] = {$urandom, $urandom};
  endtask

  task automatic load_ops(input int n);
    for (int i = 0; i < n && i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = ops[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic clear_resp();
    for (int i = 0; i < 64; i++) begin
      resp_v[i] = 1'b0;
      resp_y[i] = '0;
    end
  endtask

  // Cycle 0 is the start cycle; issues land in cycles 1..cnt, results return lat cycles later.
  task automatic run_batch(input int n, input int lat, input int mode, input bit spurious,
                           input int restart_cyc, input int wrlock_cyc, input int ruser_cyc);
    int cnt, done_cyc, last_c, n_issue, n_done, exp_issue, captured, idx;
    bit alive, exp_sta;
    cnt      = (n > DEPTH) ? DEPTH : n;
    done_cyc = (cnt == 0) ? 1 : cnt + lat + 1;
    last_c   = done_cyc + 3;
    n_issue  = 0;
    n_done   = 0;
    clear_resp();
    for (int c = 0; c <= last_c; c++) begin
      start    = (c == 0) || (c == restart_cyc);
      n_ops    = (c == 0) ? 5'(n) : 5'd3;
      rst_user = (c == ruser_cyc);
      wr_en    = (c == wrlock_cyc);
      wr_addr  = AW'(cnt - 1);
      wr_data  = ~ops[DEPTH-1];
      op_done  = resp_v[c];
      op_y     = resp_y[c];
      if (spurious && (c == done_cyc || c == done_cyc + 1)) begin
        op_done = 1'b1;
        op_y    = 64'hDEAD_BEEF_0BAD_F00D;
      end
      @(negedge clk);
      alive   = (ruser_cyc < 0) || (c <= ruser_cyc);
      exp_sta = alive && (c >= 1) && (c <= cnt);
      idx     = (c >= 1 && c <= DEPTH) ? c - 1 : 0;
      chk("op_sta", op_sta, exp_sta);
      chk("op_x", op_x, exp_sta ? ops[idx] : 64'h0);
      chk("busy", busy, alive && (cnt > 0) && (c >= 1) && (c <= cnt + lat));
      chk("done_sig", done_sig, alive && (c == done_cyc));
      if (c >= 1) chk("timeout_err", timeout_err, 1'b0);
      if (op_sta) begin
        n_issue++;
        resp_v[c + lat] = 1'b1;
        resp_y[c + lat] = f(mode, op_x);
      end
      if (done_sig) n_done++;
      tick();
    end
    start = 1'b0; rst_user = 1'b0; wr_en = 1'b0; op_done = 1'b0; op_y = '0;
    exp_issue = (ruser_cyc < 0) ? cnt : ((cnt < ruser_cyc) ? cnt : ruser_cyc);
    chk("issue_count", 64'(n_issue), 64'(exp_issue));
    chk("done_count", 64'(n_done), (ruser_cyc < 0) ? 64'd1 : 64'd0);
    captured = 0;
    for (int i = 0; i < cnt; i++)
      if (ruser_cyc < 0 || i + 1 + lat < ruser_cyc) captured++;
    for (int i = 0; i < captured; i++) begin
      rd_addr = AW'(i);
      @(posedge clk);
      @(negedge clk);
      chk("result", rd_data, f(mode, ops[i]));
    end
    tick();
  endtask

  initial begin
    int n_iss;
    #1 rst = 1'b0;
    #1;
    chk("rst_op_sta", op_sta, 1'b0);
    chk("rst_op_x", op_x, 64'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done_sig, 1'b0);
    chk("rst_tmo", timeout_err, 1'b0);
    chk("rst_rd", rd_data, 64'h0);
    tick();
    rst = 1'b1;
    tick();

    // 1.0, -2.0, 0.5, -0.0 through max(x, 0.0) with latency 2
    ops[0] = 64'h3FF0_0000_0000_0000; ops[1] = 64'hC000_0000_0000_0000;
    ops[2] = 64'h3FE0_0000_0000_0000; ops[3] = 64'h8000_0000_0000_0000;
    load_ops(4);
    run_batch(4, 2, 0, 1'b0, -1, -1, -1);

    run_batch(0, 2, 0, 1'b0, -1, -1, -1);

    // Saturation, ignored restart, and operand lock while busy
    rand_ops();
    load_ops(DEPTH);
    run_batch(20, 3, 1, 1'b0, 2, 1, -1);

    // Latency 1 overlaps issue and return; spurious op_done after the last result
    rand_ops();
    load_ops(DEPTH);
    run_batch(6, 1, 1, 1'b1, -1, -1, -1);

    for (int k = 0; k < 5; k++) begin
      rand_ops();
      load_ops(DEPTH);
      run_batch($urandom_range(1, 20), $urandom_range(1, 4), $urandom_range(0, 1),
                1'($urandom_range(0, 1)), -1, -1, -1);
    end

    // Soft clear after two of four results
    rand_ops();
    load_ops(4);
    run_batch(4, 2, 1, 1'b0, -1, -1, 5);

    // Asynchronous reset mid-issue, between clock edges
    rd_addr = '0; start = 1'b1; n_ops = 5'd4;
    tick();
    start = 1'b0;
    tick();
    @(negedge clk);
    chk("arst_pre_sta", op_sta, 1'b1);
    chk("arst_pre_x", op_x, ops[1]);
    chk("arst_pre_rd", rd_data, f(1, ops[0]));
    #2 rst = 1'b0;
    #1;
    chk("arst_op_sta", op_sta, 1'b0);
    chk("arst_op_x", op_x, 64'h0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done_sig, 1'b0);
    chk("arst_tmo", timeout_err, 1'b0);
    chk("arst_rd", rd_data, 64'h0);
    tick();
    rst = 1'b1;
    tick();

    // Operator returns only three of four results; last one captured at the end of cycle 5
    rand_ops();
    load_ops(4);
    clear_resp();
    n_iss = 0;
    for (int c = 0; c <= 30; c++) begin
      start   = (c == 0);
      n_ops   = 5'd4;
      op_done = resp_v[c];
      op_y    = resp_y[c];
      @(negedge clk);
      if (op_sta && n_iss < 3) begin
        resp_v[c + 2] = 1'b1;
        resp_y[c + 2] = f(1, op_x);
      end
      if (op_sta) n_iss++;
`ifdef PM64_TIMEOUT_EN
      chk("tmo_err", timeout_err, c >= 21);
      chk("tmo_busy", busy, (c >= 1) && (c <= 20));
`else
      chk("tmo_err", timeout_err, 1'b0);
      chk("tmo_busy", busy, c >= 1);
`endif
      chk("tmo_done", done_sig, 1'b0);
      tick();
    end
    start = 1'b0; op_done = 1'b0;
    rst_user = 1'b1;
    tick();
    rst_user = 1'b0;
    @(negedge clk);
    chk("post_clear_busy", busy, 1'b0);
    chk("post_clear_tmo", timeout_err, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
